serial_sub_seq: RTL and testbench
=================================

# serial_sub_seq

Bit-serial multi-bit subtractor controller. It accepts two WIDTH-bit unsigned operands over a valid/ready handshake and sequences a single one-bit full-subtractor cell LSB-first, one bit per clock. It then presents the difference and final borrow over a second valid/ready handshake. The block sits in the combinational-circuits arithmetic area as the sequenced, area-minimal alternative to a parallel ripple subtractor.

## Interface
Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands A/B valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  minuend, unsigned.
- B  in  WIDTH  subtrahend, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Diff  out  WIDTH  (A − B) mod 2^WIDTH.
- Borrow  out  1  final borrow; 1 iff A < B unsigned.
- busy  out  1  high in RUN.
- Zero  out  1  present only with SERIAL_SUB_ZERO_EN; 1 iff Diff == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. An input handshake (in_valid & in_ready) loads A and B into shift registers a_sh and b_sh. It clears borrow_r and bit_cnt, clears diff_sh, and moves to RUN.
- RUN: each cycle the cell computes d = a_sh[0]^b_sh[0]^borrow_r and bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow_r).
  - a_sh and b_sh shift right. d shifts into diff_sh from the MSB side. borrow_r ← bo. bit_cnt increments.
  - When bit_cnt == WIDTH−1, the last bit is processed and the FSM moves to DONE.
- DONE: out_valid=1. Diff = diff_sh. Borrow = borrow_r.
  - Outputs hold stable until out_ready is sampled high.
  - On the output handshake, go to IDLE.
- No input handshake is accepted in RUN or DONE, so in_ready=0 there. Operands are never dropped; in_valid may stay high while the block is busy.
- Reset (async, any state, including mid-RUN): FSM→IDLE, in_ready=1, out_valid=0, busy=0, Diff=0, Borrow=0, Zero=0. All internal registers clear. A partial computation is discarded; no out_valid is ever produced for it.
- Widths: bit_cnt is $clog2(WIDTH) bits; its terminal compare uses WIDTH−1. The borrow out of the MSB is the Borrow output; no sign interpretation is applied.

## Timing
- Input handshake in cycle 0 → RUN for cycles 1..WIDTH → out_valid high from cycle WIDTH+1. Latency is WIDTH+1 cycles from accept to result.
- Minimum issue interval is WIDTH+2 cycles: the DONE→IDLE handshake costs one cycle, and the next accept happens in the IDLE cycle.
- If out_ready is already high when DONE is entered, the result handshakes in that first DONE cycle.
- out_ready low stalls the block indefinitely in DONE with outputs frozen.
- All outputs are registered or decoded from state. There are no combinational paths from in_valid/out_ready to outputs, except that in_ready depends only on state.

## Configuration
- SERIAL_SUB_ZERO_EN defined: the Zero port exists. zero_r is set in IDLE at accept. It is cleared on any d=1 during RUN, and is valid with out_valid.
- Not defined: the Zero port and zero_r are absent. All other behaviour is identical.

## Structure
- Shared package serial_sub_pkg holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the localparam for the default WIDTH.
- One sub-module: fullsub_cell (inputs a, b, bin; outputs d, bout). It is purely combinational and instantiated once.

## Test plan
- Reset, then A=8'h05, B=8'h03 → after 9 cycles, Diff=8'h02, Borrow=0 (Zero=0 if enabled).
- A=8'h03, B=8'h05 → Diff=8'hFE, Borrow=1.
- A=8'h00, B=8'h01 → Diff=8'hFF, Borrow=1. Also A=8'hAA, B=8'hAA → Diff=8'h00, Borrow=0, Zero=1.
- Hold out_ready=0 for 20 cycles in DONE with in_valid high and new operands → outputs stable, in_ready=0, no second accept. Release → handshake, next accept in the following IDLE cycle.
- Assert rst_n low at RUN cycle 4 → all outputs 0 and in_ready=1 immediately. Next op A=8'h10, B=8'h01 → Diff=8'h0F, Borrow=0.
- Randomized 1000 ops (WIDTH=8 and WIDTH=13) with random out_ready backpressure → Diff and Borrow match (A−B) mod 2^WIDTH and A<B.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fullsub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out of this bit.
module fullsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub_seq.sv
// Bit-serial WIDTH-bit subtractor, LSB-first, one bit per clock, valid/ready on both sides.
// Optional Zero flag output is enabled by defining SERIAL_SUB_ZERO_EN.
module serial_sub_seq
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             busy,
`ifdef SERIAL_SUB_ZERO_EN
  output logic             Zero,
`endif
  output state_t           dbg_state
);
  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic [CW-1:0]    bit_cnt;
  logic             borrow_r;
  logic             cell_d, cell_bo;

  fullsub_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (borrow_r),
    .d   (cell_d),
    .bout(cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (bit_cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      bit_cnt  <= '0;
      borrow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh     <= A;
          b_sh     <= B;
          diff_sh  <= '0;
          bit_cnt  <= '0;
          borrow_r <= 1'b0;
        end
        RUN: begin
          // Result bits enter at the MSB so after WIDTH shifts bit 0 holds the first difference bit.
          a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
          diff_sh  <= {cell_d, diff_sh[WIDTH-1:1]};
          borrow_r <= cell_bo;
          bit_cnt  <= bit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_EN
  logic zero_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          zero_r <= 1'b0;
    else if (state == IDLE && in_valid)  zero_r <= 1'b1;
    else if (state == RUN && cell_d)     zero_r <= 1'b0;
  end
  assign Zero = zero_r;
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign Diff      = diff_sh;
  assign Borrow    = borrow_r;
  assign dbg_state = state;
endmodule

// File: tb/tb_serial_sub_seq.sv
// Directed table, hold/reset corner sequences and random backpressure runs for serial_sub_seq.
module tb_serial_sub_seq;
  import serial_sub_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, borrow, busy, zero;
  logic [7:0] a, b, diff;
  state_t     dbg;
  logic        in_valid13, in_ready13, out_valid13, out_ready13, borrow13, busy13, zero13;
  logic [12:0] a13, b13, diff13;
  state_t      dbg13;

  serial_sub_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .Diff(diff), .Borrow(borrow), .busy(busy),
`ifdef SERIAL_SUB_ZERO_EN
    .Zero(zero),
`endif
    .dbg_state(dbg)
  );

  serial_sub_seq #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready13), .A(a13), .B(b13),
    .out_valid(out_valid13), .out_ready(out_ready13), .Diff(diff13), .Borrow(borrow13),
    .busy(busy13),
`ifdef SERIAL_SUB_ZERO_EN
    .Zero(zero13),
`endif
    .dbg_state(dbg13)
  );

`ifndef SERIAL_SUB_ZERO_EN
  assign zero   = 1'b0;
  assign zero13 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0]  exp_q[$];
  logic [13:0] exp_q13[$];

  typedef struct {
    logic [7:0] a, b, diff;
    logic       borrow, zero;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] va, input logic [7:0] vb);
    a = va; b = vb; in_valid = 1'b1;
    check("accept_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic rand_ops8(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] ra, rb;
      logic [8:0] e;
      int  cyc;
      logic got;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back({ra < rb, 8'(ra - rb)});
      accept8(ra, rb);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          e = exp_q.pop_front();
          check("rand8_diff", 32'(diff), 32'(e[7:0]));
          check("rand8_borrow", 32'(borrow), 32'(e[8]));
          got = 1'b1;
        end
        step();
        cyc++;
      end
      if (!got) check("rand8_timeout", 32'd0, 32'd1);
    end
    out_ready = 1'b0;
  endtask

  task automatic rand_ops13(input int n);
    for (int i = 0; i < n; i++) begin
      logic [12:0] ra, rb;
      logic [13:0] e;
      int   cyc;
      logic got;
      ra = 13'($urandom_range(0, 8191));
      rb = (i % 16 == 0) ? ra : 13'($urandom_range(0, 8191));
      exp_q13.push_back({ra < rb, 13'(ra - rb)});
      a13 = ra; b13 = rb; in_valid13 = 1'b1;
      check("rand13_in_ready", 32'(in_ready13), 32'd1);
      step();
      in_valid13 = 1'b0;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
        out_ready13 = 1'($urandom_range(0, 1));
        if (out_valid13 && out_ready13) begin
          e = exp_q13.pop_front();
          check("rand13_diff", 32'(diff13), 32'(e[12:0]));
          check("rand13_borrow", 32'(borrow13), 32'(e[13]));
`ifdef SERIAL_SUB_ZERO_EN
          check("rand13_zero", 32'(zero13), 32'(e[12:0] == 13'd0));
`endif
          got = 1'b1;
        end
        step();
        cyc++;
      end
      if (!got) check("rand13_timeout", 32'd0, 32'd1);
    end
    out_ready13 = 1'b0;
  endtask

  initial begin
    logic seen;
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid13 = 1'b0; out_ready13 = 1'b0; a13 = '0; b13 = '0;
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_state", 32'(dbg), 32'(IDLE));
    check("rst_state13", 32'(dbg13), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // Directed table
    foreach (vecs[i]) begin
      accept8(vecs[i].a, vecs[i].b);
      check("run_busy", 32'(busy), 32'd1);
      check("run_in_ready", 32'(in_ready), 32'd0);
      repeat (7) step();
      check("early_out_valid", 32'(out_valid), 32'd0);
      step();
      check("latency_out_valid", 32'(out_valid), 32'd1);
      check("vec_diff", 32'(diff), 32'(vecs[i].diff));
      check("vec_borrow", 32'(borrow), 32'(vecs[i].borrow));
`ifdef SERIAL_SUB_ZERO_EN
      check("vec_zero", 32'(zero), 32'(vecs[i].zero));
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
    end

    // Backpressure hold in DONE with new operands pending
    accept8(8'h12, 8'h34);
    repeat (8) step();
    a = 8'h77; b = 8'h11; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_diff", 32'(diff), 32'hDE);
      check("hold_borrow", 32'(borrow), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("reaccept_busy", 32'(busy), 32'd1);
    repeat (8) step();
    check("reaccept_out_valid", 32'(out_valid), 32'd1);
    check("reaccept_diff", 32'(diff), 32'h66);
    check("reaccept_borrow", 32'(borrow), 32'd0);
    step();
    out_ready = 1'b0;

    // Asynchronous reset in the fourth RUN cycle
    accept8(8'hFF, 8'h01);
    repeat (3) step();
    check("mid_state", 32'(dbg), 32'(RUN));
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    check("arst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_result", 32'(seen), 32'd0);
    out_ready = 1'b0;
    accept8(8'h10, 8'h01);
    repeat (8) step();
    check("after_rst_valid", 32'(out_valid), 32'd1);
    check("after_rst_diff", 32'(diff), 32'h0F);
    check("after_rst_borrow", 32'(borrow), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Random backpressure runs at both widths
    rand_ops8(1000);
    rand_ops13(1000);
    check("q8_empty", 32'(exp_q.size()), 32'd0);
    check("q13_empty", 32'(exp_q13.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
